// File: rtl/system_auto_cc_0_rd_ptr_pkg.sv
// Shared definitions for the async-FIFO pointer blocks (read side and write side).
//   PTR_W  : pointer width (one extra bit over the address for full/empty).
//   ADDR_W : RAM address width.
//   DEPTH  : RAM depth in words.
//   gray2bin / bin2gray : pointer code conversions.
//   out_state_t : state of the read-side output holding stage.
package system_auto_cc_0_rd_ptr_pkg;

    localparam int unsigned PTR_W  = 4;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int unsigned i = PTR_W - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/system_auto_cc_0_rd_out_stage.sv
// Output holding stage of the FIFO read side: tracks whether m_data (the RAM
// output register) currently holds a word the consumer has not yet taken.
//   s_aclk  : read-domain clock
//   rd_rst  : synchronous active-high reset; discards any held word
//   fetch   : a RAM read is issued this cycle (word appears next cycle)
//   m_ready : consumer accepts the held word
//   m_valid : a word is held
module system_auto_cc_0_rd_out_stage
    import system_auto_cc_0_rd_ptr_pkg::*;
(
    input  logic s_aclk,
    input  logic rd_rst,
    input  logic fetch,
    input  logic m_ready,
    output logic m_valid
);

    out_state_t state_q;
    out_state_t state_d;

    always_ff @(posedge s_aclk) begin
        if (rd_rst) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A fetch always refills the stage, so accept-plus-fetch stays FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (fetch) state_d = OUT_FULL;
            OUT_FULL:  if (m_ready && !fetch) state_d = OUT_EMPTY;
            default:   state_d = OUT_EMPTY;
        endcase
    end

    assign m_valid = (state_q == OUT_FULL);

endmodule

// File: rtl/system_auto_cc_0_rd_ptr_ctrl.sv
// Read-side pointer control of an 8-deep asynchronous FIFO.
//   s_aclk, rd_rst       : read clock, synchronous active-high reset
//   wr_ptr_gray_sync     : synchronized Gray write pointer
//   ram_rd_data          : RAM read data (valid one cycle after ram_rd_en, held otherwise)
//   m_ready              : consumer ready
//   ram_rd_en/ram_rd_addr: RAM read strobe and address
//   rd_ptr_gray          : registered Gray read pointer for the write domain
//   m_valid/m_data       : output word handshake
//   empty                : nothing left to fetch
//   rd_count             : unread words not yet fetched
//   ptr_err              : sticky flag for pointer distance beyond DEPTH
module system_auto_cc_0_rd_ptr_ctrl
    import system_auto_cc_0_rd_ptr_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              s_aclk,
    input  logic              rd_rst,
    input  logic [PTR_W-1:0]  wr_ptr_gray_sync,
    input  logic [DATA_W-1:0] ram_rd_data,
    input  logic              m_ready,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [PTR_W-1:0]  rd_ptr_gray,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              empty,
    output logic [PTR_W-1:0]  rd_count,
    output logic              ptr_err
);

    logic [PTR_W-1:0] wr_bin_q;
    logic [PTR_W-1:0] rd_bin;
    logic [PTR_W-1:0] rd_bin_next;
    logic             fetch;

    // Forcing empty during reset keeps the RAM idle while rd_rst is high.
    assign empty       = rd_rst || (rd_bin == wr_bin_q);
    assign fetch       = !empty && (!m_valid || m_ready);
    assign ram_rd_en   = fetch;
    assign ram_rd_addr = rd_bin[ADDR_W-1:0];
    assign rd_bin_next = rd_bin + PTR_W'(fetch);
    assign rd_count    = wr_bin_q - rd_bin;

    // The RAM output register holds its word while ram_rd_en is low,
    // so it doubles as the output data register.
    assign m_data = ram_rd_data;

    always_ff @(posedge s_aclk) begin
        if (rd_rst) begin
            wr_bin_q    <= '0;
            rd_bin      <= '0;
            rd_ptr_gray <= '0;
            ptr_err     <= 1'b0;
        end else begin
            wr_bin_q    <= gray2bin(wr_ptr_gray_sync);
            rd_bin      <= rd_bin_next;
            rd_ptr_gray <= bin2gray(rd_bin_next);
            if (rd_count > PTR_W'(DEPTH)) begin
                ptr_err <= 1'b1;
            end
        end
    end

    system_auto_cc_0_rd_out_stage u_out_stage (
        .s_aclk  (s_aclk),
        .rd_rst  (rd_rst),
        .fetch   (fetch),
        .m_ready (m_ready),
        .m_valid (m_valid)
    );

endmodule

// File: tb/tb_system_auto_cc_0_rd_ptr_ctrl.sv
// Directed testbench for system_auto_cc_0_rd_ptr_ctrl with a small RAM model.
module tb_system_auto_cc_0_rd_ptr_ctrl;

    logic       s_aclk = 1'b0;
    logic       rd_rst;
    logic [3:0] wr_ptr_gray_sync;
    logic [7:0] ram_rd_data;
    logic       m_ready;
    logic       ram_rd_en;
    logic [2:0] ram_rd_addr;
    logic [3:0] rd_ptr_gray;
    logic       m_valid;
    logic [7:0] m_data;
    logic       empty;
    logic [3:0] rd_count;
    logic       ptr_err;

    logic [7:0] mem [8];

    int total     = 0;
    int bad       = 0;
    int fetch_cnt = 0;
    int n_acc     = 0;
    bit chk_acc   = 1'b0;
    bit seen15    = 1'b0;

    always #5 s_aclk = ~s_aclk;

    system_auto_cc_0_rd_ptr_ctrl #(.DATA_W(8)) dut (
        .s_aclk           (s_aclk),
        .rd_rst           (rd_rst),
        .wr_ptr_gray_sync (wr_ptr_gray_sync),
        .ram_rd_data      (ram_rd_data),
        .m_ready          (m_ready),
        .ram_rd_en        (ram_rd_en),
        .ram_rd_addr      (ram_rd_addr),
        .rd_ptr_gray      (rd_ptr_gray),
        .m_valid          (m_valid),
        .m_data           (m_data),
        .empty            (empty),
        .rd_count         (rd_count),
        .ptr_err          (ptr_err)
    );

    // RAM model: registered read, output held while ram_rd_en is low.
    always @(posedge s_aclk) begin
        if (ram_rd_en === 1'b1) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: sample stable outputs at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge s_aclk);
        if (ram_rd_en === 1'b1) fetch_cnt++;
        if (rd_ptr_gray === 4'b1000) seen15 = 1'b1;
        if (chk_acc && m_valid === 1'b1 && m_ready === 1'b1) begin
            chk("acc_data", 32'(m_data), 32'(8'hA0 + 8'(n_acc % 8)));
            n_acc++;
        end
        @(posedge s_aclk);
        #2;
    endtask

    task automatic reset_dut(input logic [3:0] g);
        rd_rst           = 1'b1;
        wr_ptr_gray_sync = g;
        m_ready          = 1'b0;
        tick();
        tick();
        rd_rst    = 1'b0;
        fetch_cnt = 0;
        n_acc     = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
        chk_acc = 1'b0;

        // Reset: Gray 0011 -> binary 2.
        reset_dut(4'b0011);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rd_ptr_gray", 32'(rd_ptr_gray), 32'd0);
        chk("rst_ram_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst_ptr_err", 32'(ptr_err), 32'd0);
        tick();
        chk("rel_rd_count", 32'(rd_count), 32'd2);
        chk("rel_empty", 32'(empty), 32'd0);

        // Streaming: Gray 0 -> 1 -> 3 -> 2 with m_ready high.
        reset_dut(4'b0000);
        chk_acc = 1'b1;
        m_ready = 1'b1;
        wr_ptr_gray_sync = 4'b0001;
        tick();
        chk("str_rd_en0", 32'(ram_rd_en), 32'd1);
        chk("str_addr0", 32'(ram_rd_addr), 32'd0);
        chk("str_valid0", 32'(m_valid), 32'd0);
        wr_ptr_gray_sync = 4'b0011;
        tick();
        chk("str_valid1", 32'(m_valid), 32'd1);
        chk("str_addr1", 32'(ram_rd_addr), 32'd1);
        chk("str_data1", 32'(m_data), 32'hA0);
        wr_ptr_gray_sync = 4'b0010;
        tick();
        chk("str_valid2", 32'(m_valid), 32'd1);
        chk("str_addr2", 32'(ram_rd_addr), 32'd2);
        chk("str_data2", 32'(m_data), 32'hA1);
        tick();
        chk("str_valid3", 32'(m_valid), 32'd1);
        chk("str_data3", 32'(m_data), 32'hA2);
        chk("str_empty", 32'(empty), 32'd1);
        chk("str_rd_en3", 32'(ram_rd_en), 32'd0);
        chk("str_rd_ptr_gray", 32'(rd_ptr_gray), 32'b0010);
        tick();
        chk("str_valid_end", 32'(m_valid), 32'd0);
        chk("str_fetches", 32'(fetch_cnt), 32'd3);
        chk("str_accepts", 32'(n_acc), 32'd3);

        // Backpressure: 4 words available (Gray 0110), m_ready low.
        reset_dut(4'b0110);
        tick();
        chk("bp_count4", 32'(rd_count), 32'd4);
        chk("bp_rd_en", 32'(ram_rd_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", 32'(m_valid), 32'd1);
            chk("bp_hold_data", 32'(m_data), 32'hA0);
            chk("bp_hold_count", 32'(rd_count), 32'd3);
            chk("bp_hold_rd_en", 32'(ram_rd_en), 32'd0);
        end
        chk("bp_one_fetch", 32'(fetch_cnt), 32'd1);
        m_ready = 1'b1;
        tick();
        chk("bp_drain1", 32'(m_data), 32'hA1);
        tick();
        chk("bp_drain2", 32'(m_data), 32'hA2);
        tick();
        chk("bp_drain3", 32'(m_data), 32'hA3);
        chk("bp_drain_valid", 32'(m_valid), 32'd1);
        chk("bp_empty", 32'(empty), 32'd1);
        tick();
        chk("bp_done_valid", 32'(m_valid), 32'd0);
        chk("bp_fetches", 32'(fetch_cnt), 32'd4);
        chk("bp_accepts", 32'(n_acc), 32'd4);

        // Wrap: write pointer advances one per cycle to 20 (binary 4 after wrap).
        reset_dut(4'b0000);
        m_ready = 1'b1;
        seen15  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            logic [3:0] b;
            b = 4'(i);
            wr_ptr_gray_sync = b ^ (b >> 1);
            tick();
        end
        for (int i = 0; i < 4; i++) tick();
        chk("wrap_fetches", 32'(fetch_cnt), 32'd20);
        chk("wrap_seen15", 32'(seen15), 32'd1);
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_rd_ptr_gray", 32'(rd_ptr_gray), 32'b0110);
        chk("wrap_addr", 32'(ram_rd_addr), 32'd4);
        chk("wrap_count", 32'(rd_count), 32'd0);
        chk("wrap_ptr_err", 32'(ptr_err), 32'd0);
        chk("wrap_accepts", 32'(n_acc), 32'd20);
        chk_acc = 1'b0;

        // Error: binary write pointer 9 (Gray 1101) with rd_bin 0.
        reset_dut(4'b1101);
        tick();
        chk("err_count9", 32'(rd_count), 32'd9);
        chk("err_not_yet", 32'(ptr_err), 32'd0);
        tick();
        chk("err_set", 32'(ptr_err), 32'd1);
        wr_ptr_gray_sync = 4'b0001;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("err_sticky", 32'(ptr_err), 32'd1);
        rd_rst = 1'b1;
        tick();
        chk("err_cleared", 32'(ptr_err), 32'd0);
        rd_rst = 1'b0;

        // Mid-operation reset with a held word and 5 unread.
        reset_dut(4'b0101);
        tick();
        chk("mid_count6", 32'(rd_count), 32'd6);
        tick();
        chk("mid_valid", 32'(m_valid), 32'd1);
        chk("mid_count5", 32'(rd_count), 32'd5);
        rd_rst = 1'b1;
        #1;
        chk("mid_rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        tick();
        chk("mid_valid_clr", 32'(m_valid), 32'd0);
        chk("mid_addr", 32'(ram_rd_addr), 32'd0);
        chk("mid_rd_ptr_gray", 32'(rd_ptr_gray), 32'd0);
        tick();
        chk("mid_no_fetch", 32'(fetch_cnt), 32'd1);
        rd_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
